// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions for the multi-cycle core: word/opcode widths, opcode
// values, controller state encoding, ALU operation and operand-select
// encodings (the Datapath decodes the same values), the bundled control
// word driven by the controller, and small helpers for the execute-phase
// ALU setup.
// -----------------------------------------------------------------------------
package control_unit_pkg;

    localparam int SIZE_WORD = 16;
    localparam int OP_W      = 4;

    // Opcode values found in inst[SIZE_WORD-1 -: OP_W]; 4'hA..4'hE are illegal.
    localparam logic [OP_W-1:0] OPC_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OPC_ADC  = 4'h1;
    localparam logic [OP_W-1:0] OPC_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OPC_AND  = 4'h3;
    localparam logic [OP_W-1:0] OPC_OR   = 4'h4;
    localparam logic [OP_W-1:0] OPC_ADDI = 4'h5;
    localparam logic [OP_W-1:0] OPC_LD   = 4'h6;
    localparam logic [OP_W-1:0] OPC_ST   = 4'h7;
    localparam logic [OP_W-1:0] OPC_BEQ  = 4'h8;
    localparam logic [OP_W-1:0] OPC_JMP  = 4'h9;
    localparam logic [OP_W-1:0] OPC_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB       = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd10
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_PASSB = 4'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_PC   = 2'd0,
        SRCA_REG  = 2'd1,
        SRCA_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'd0,
        SRCB_ONE   = 2'd1,
        SRCB_SEXT4 = 2'd2,
        SRCB_ZEXT4 = 2'd3
    } alu_src_b_e;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pvs_write;
        alu_src_a_e alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        logic       carry;
        logic       halted;
    } ctrl_t;

    // All enables low, ALU left at PC + regB with ADD.
    localparam ctrl_t CTRL_IDLE = '0;

    // ALU operation for the register-register group.
    function automatic alu_op_e rtype_alu_op(input logic [OP_W-1:0] opc);
        alu_op_e op;
        case (opc)
            OPC_ADD: op = ALU_ADD;
            OPC_ADC: op = ALU_ADD;
            OPC_SUB: op = ALU_SUB;
            OPC_AND: op = ALU_AND;
            OPC_OR:  op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // ALU setup of the execute phase. Writeback re-derives it from the still
    // latched opcode so the ALU result stays stable while it is written.
    function automatic ctrl_t exec_ctrl(input logic [OP_W-1:0] opc,
                                        input logic            carry_flag);
        ctrl_t c;
        c = CTRL_IDLE;
        if (opc == OPC_ADDI) begin
            c.alu_src_a = SRCA_REG;
            c.alu_src_b = SRCB_SEXT4;
            c.alu_op    = ALU_ADD;
        end else begin
            c.alu_src_a = SRCA_REG;
            c.alu_src_b = SRCB_REG;
            c.alu_op    = rtype_alu_op(opc);
            c.carry     = (opc == OPC_ADC) ? carry_flag : 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// -----------------------------------------------------------------------------
// control_unit_decode
// Combinational map from controller state, latched opcode, stored carry
// and memory handshake to the full control word.
//   state_i      current controller state
//   opcode_i     opcode field of the latched instruction register
//   carry_flag_i stored PVS carry bit (carry-in for ADC)
//   mem_ready_i  memory finishes the current access this cycle
//   quiet_i      first cycle after reset: force every output idle
//   ctrl_o       control word (enables, ALU selects, carry-in, halted)
// -----------------------------------------------------------------------------
module control_unit_decode
    import control_unit_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] opcode_i,
    input  logic            carry_flag_i,
    input  logic            mem_ready_i,
    input  logic            quiet_i,
    output ctrl_t           ctrl_o
);

    // Control word decode; everything defaults to idle first.
    always_comb begin
        ctrl_o = CTRL_IDLE;
        if (quiet_i) begin
            ctrl_o = CTRL_IDLE;
        end else begin
            case (state_i)
                S_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_a = SRCA_PC;
                    ctrl_o.alu_src_b = SRCB_ONE;
                    ctrl_o.alu_op    = ALU_ADD;
                    // IR and PC only move on the cycle the word arrives.
                    if (mem_ready_i) begin
                        ctrl_o.ir_write = 1'b1;
                        ctrl_o.pc_write = 1'b1;
                    end else begin
                        ctrl_o.ir_write = 1'b0;
                        ctrl_o.pc_write = 1'b0;
                    end
                end
                S_DECODE: begin
                    ctrl_o = CTRL_IDLE;
                end
                S_EXEC_R, S_EXEC_I: begin
                    ctrl_o = exec_ctrl(opcode_i, carry_flag_i);
                end
                S_WB: begin
                    ctrl_o           = exec_ctrl(opcode_i, carry_flag_i);
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.pvs_write = 1'b1;
                end
                S_MEM_ADDR: begin
                    ctrl_o.alu_src_a = SRCA_REG;
                    ctrl_o.alu_src_b = SRCB_ZEXT4;
                    ctrl_o.alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    // Loaded data lands in the register file; flags untouched.
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.reg_write = mem_ready_i;
                end
                S_MEM_WR: begin
                    ctrl_o.mem_write = 1'b1;
                end
                S_BRANCH: begin
                    // regA - regB sets zero; the Datapath gates PCWriteCond with it.
                    ctrl_o.alu_src_a     = SRCA_REG;
                    ctrl_o.alu_src_b     = SRCB_REG;
                    ctrl_o.alu_op        = ALU_SUB;
                    ctrl_o.pc_write_cond = 1'b1;
                end
                S_JUMP: begin
                    ctrl_o.pc_write  = 1'b1;
                    ctrl_o.alu_src_a = SRCA_ZERO;
                    ctrl_o.alu_src_b = SRCB_SEXT4;
                    ctrl_o.alu_op    = ALU_ADD;
                end
                S_HALT: begin
                    ctrl_o.halted = 1'b1;
                end
                default: begin
                    ctrl_o = CTRL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multi-cycle control FSM sitting beside the Datapath. One state per cycle:
// FETCH, DECODE, then EXEC_R/EXEC_I + WB, MEM_ADDR + MEM_RD/MEM_WR, BRANCH,
// JUMP or HALT. With memory ready immediately: R/I-type 4 cycles, LD and ST
// 4, BEQ/JMP 3; every memory wait cycle adds one. Outputs are decoded from
// the state register and the latched instruction; FETCH and MEM_RD also
// qualify their write enables with mem_ready.
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   inst             instruction register contents from the Datapath
//   zero             ALU zero (consumed by the Datapath's PCWriteCond gate)
//   carry_flag       stored PVS carry, ALU carry-in for ADC
//   mem_ready        memory completes the current access this cycle
//   IRWriteEn .. PVSWriteEn   write enables / memory requests
//   ALUSrcA, ALUSrcB, ALUOp, carry   ALU controls
//   halted           core stopped; only reset leaves HALT
// -----------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SIZE_WORD-1:0] inst,
    input  logic                 zero,
    input  logic                 carry_flag,
    input  logic                 mem_ready,
    output logic                 IRWriteEn,
    output logic                 PCWriteEn,
    output logic                 PCWriteCond,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWriteEn,
    output logic                 PVSWriteEn,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUOp,
    output logic                 carry,
    output logic                 halted
);

    state_e          state_q;
    state_e          state_d;
    logic            quiet_q;
    logic [OP_W-1:0] opcode_s;
    ctrl_t           ctrl_s;
    logic            unused_s;

    assign opcode_s = inst[SIZE_WORD-1 -: OP_W];

    // Operand fields and the zero flag are used by the Datapath, not here.
    assign unused_s = ^{inst[SIZE_WORD-OP_W-1:0], zero};

    // State register. quiet_q marks the reset state: the cycle after reset
    // is sampled sits in FETCH with every output low, so an aborted memory
    // access is dropped before a new fetch is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            quiet_q <= 1'b1;
        end else begin
            state_q <= state_d;
            quiet_q <= 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (quiet_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode_s)
                        OPC_ADD, OPC_ADC, OPC_SUB,
                        OPC_AND, OPC_OR:           state_d = S_EXEC_R;
                        OPC_ADDI:                  state_d = S_EXEC_I;
                        OPC_LD, OPC_ST:            state_d = S_MEM_ADDR;
                        OPC_BEQ:                   state_d = S_BRANCH;
                        OPC_JMP:                   state_d = S_JUMP;
                        OPC_HALT:                  state_d = S_HALT;
                        default:                   state_d = S_FETCH;
                    endcase
                end
                S_EXEC_R:   state_d = S_WB;
                S_EXEC_I:   state_d = S_WB;
                S_WB:       state_d = S_FETCH;
                S_MEM_ADDR: state_d = (opcode_s == OPC_LD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state_d = mem_ready ? S_FETCH : S_MEM_RD;
                S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
                S_BRANCH:   state_d = S_FETCH;
                S_JUMP:     state_d = S_FETCH;
                S_HALT:     state_d = S_HALT;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    control_unit_decode u_decode (
        .state_i      (state_q),
        .opcode_i     (opcode_s),
        .carry_flag_i (carry_flag),
        .mem_ready_i  (mem_ready),
        .quiet_i      (quiet_q),
        .ctrl_o       (ctrl_s)
    );

    assign IRWriteEn   = ctrl_s.ir_write;
    assign PCWriteEn   = ctrl_s.pc_write;
    assign PCWriteCond = ctrl_s.pc_write_cond;
    assign MemRead     = ctrl_s.mem_read;
    assign MemWrite    = ctrl_s.mem_write;
    assign RegWriteEn  = ctrl_s.reg_write;
    assign PVSWriteEn  = ctrl_s.pvs_write;
    assign ALUSrcA     = ctrl_s.alu_src_a;
    assign ALUSrcB     = ctrl_s.alu_src_b;
    assign ALUOp       = ctrl_s.alu_op;
    assign carry       = ctrl_s.carry;
    assign halted      = ctrl_s.halted;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed plus random instruction streams. For each instruction the bench
// plans the expected per-cycle control vectors from the instruction-class
// rules (fetch with waits, decode, class-specific phases, memory waits),
// plays the Datapath/memory side, and compares every cycle.
// -----------------------------------------------------------------------------
module tb_control_unit;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       pcc;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       pvs;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] op;
        logic       cy;
        logic       hlt;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic        rdy;
        logic        load;
        logic [15:0] nxt;
    } step_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] inst = 16'h0000;
    logic        zero = 1'b0;
    logic        carry_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        IRWriteEn, PCWriteEn, PCWriteCond, MemRead, MemWrite;
    logic        RegWriteEn, PVSWriteEn, carry, halted;
    logic [1:0]  ALUSrcA, ALUSrcB;
    logic [3:0]  ALUOp;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    step_t q[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .inst        (inst),
        .zero        (zero),
        .carry_flag  (carry_flag),
        .mem_ready   (mem_ready),
        .IRWriteEn   (IRWriteEn),
        .PCWriteEn   (PCWriteEn),
        .PCWriteCond (PCWriteCond),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWriteEn  (RegWriteEn),
        .PVSWriteEn  (PVSWriteEn),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .carry       (carry),
        .halted      (halted)
    );

    function automatic logic rbit();
        logic b;
        b = ($urandom_range(0, 1) != 0);
        return b;
    endfunction

    function automatic ctl_t alu(input logic [1:0] a, input logic [1:0] b,
                                 input logic [3:0] op);
        ctl_t c;
        c = '0;
        c.a = a;
        c.b = b;
        c.op = op;
        return c;
    endfunction

    task automatic push(input ctl_t c, input logic rdy, input logic load,
                        input logic [15:0] nxt);
        step_t s;
        s.c = c;
        s.rdy = rdy;
        s.load = load;
        s.nxt = nxt;
        q.push_back(s);
    endtask

    // Expected cycle sequence of one instruction: fw fetch waits, mw memory waits.
    task automatic plan(input logic [15:0] ins, input int fw, input int mw,
                        input logic cf, input int halt_cycles);
        ctl_t c;
        logic [3:0] opc;
        logic [3:0] rop;
        opc = ins[15:12];
        c = alu(2'd0, 2'd1, 4'd0);
        c.mr = 1'b1;
        for (int i = 0; i < fw; i++) push(c, 1'b0, 1'b0, 16'h0);
        c.irw = 1'b1;
        c.pcw = 1'b1;
        push(c, 1'b1, 1'b1, ins);
        push('0, rbit(), 1'b0, 16'h0);
        case (opc)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                rop = (opc == 4'h2) ? 4'd1 : (opc == 4'h3) ? 4'd2 :
                      (opc == 4'h4) ? 4'd3 : 4'd0;
                c = alu(2'd1, 2'd0, rop);
                c.cy = (opc == 4'h1) ? cf : 1'b0;
                push(c, rbit(), 1'b0, 16'h0);
                c.rw = 1'b1;
                c.pvs = 1'b1;
                push(c, rbit(), 1'b0, 16'h0);
            end
            4'h5: begin
                c = alu(2'd1, 2'd2, 4'd0);
                push(c, rbit(), 1'b0, 16'h0);
                c.rw = 1'b1;
                c.pvs = 1'b1;
                push(c, rbit(), 1'b0, 16'h0);
            end
            4'h6, 4'h7: begin
                push(alu(2'd1, 2'd3, 4'd0), rbit(), 1'b0, 16'h0);
                c = '0;
                if (opc == 4'h6) c.mr = 1'b1;
                else c.mw = 1'b1;
                for (int i = 0; i < mw; i++) push(c, 1'b0, 1'b0, 16'h0);
                if (opc == 4'h6) c.rw = 1'b1;
                push(c, 1'b1, 1'b0, 16'h0);
            end
            4'h8: begin
                c = alu(2'd1, 2'd0, 4'd1);
                c.pcc = 1'b1;
                push(c, rbit(), 1'b0, 16'h0);
            end
            4'h9: begin
                c = alu(2'd2, 2'd2, 4'd0);
                c.pcw = 1'b1;
                push(c, rbit(), 1'b0, 16'h0);
            end
            4'hF: begin
                c = '0;
                c.hlt = 1'b1;
                for (int i = 0; i < halt_cycles; i++) push(c, rbit(), 1'b0, 16'h0);
            end
            default: begin
                // illegal opcode: decode then straight back to fetch
            end
        endcase
    endtask

    task automatic check(input ctl_t expv, input string tag);
        ctl_t obs;
        obs.irw = IRWriteEn;
        obs.pcw = PCWriteEn;
        obs.pcc = PCWriteCond;
        obs.mr  = MemRead;
        obs.mw  = MemWrite;
        obs.rw  = RegWriteEn;
        obs.pvs = PVSWriteEn;
        obs.a   = ALUSrcA;
        obs.b   = ALUSrcB;
        obs.op  = ALUOp;
        obs.cy  = carry;
        obs.hlt = halted;
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Plays the planned steps (at most limit of them), checking each cycle.
    task automatic run(input string name, input logic cf, input int limit);
        step_t s;
        int n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            s = q.pop_front();
            mem_ready = s.rdy;
            carry_flag = cf;
            @(negedge clk);
            check(s.c, $sformatf("%s cyc%0d", name, n));
            @(posedge clk);
            #1;
            if (s.load) inst = s.nxt;
            n++;
        end
        q.delete();
    endtask

    // Reset for n cycles; outputs must read idle from the first reset edge
    // through the cycle after release.
    task automatic do_reset(input int n);
        reset = 1'b1;
        mem_ready = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k == n) reset = 1'b0;
            @(negedge clk);
            check('0, $sformatf("reset%0d", k));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string name, input logic [15:0] ins, input int fw,
                       input int mw, input logic cf);
        plan(ins, fw, mw, cf, 0);
        run(name, cf, 1000);
    endtask

    initial begin
        logic [15:0] ins;
        logic cf;
        do_reset(2);

        one("add", 16'h0123, 0, 0, rbit());
        one("adc_c1", 16'h1123, 0, 0, 1'b1);
        one("adc_c0", 16'h1123, 0, 0, 1'b0);
        one("ld_wait3", 16'h6120, 0, 3, 1'b0);
        one("beq", 16'h8120, 0, 0, 1'b0);
        one("illegal", 16'hB000, 0, 0, 1'b0);
        one("sub_fw2", 16'h2456, 2, 0, 1'b1);
        one("and", 16'h3456, 1, 0, 1'b0);
        one("or", 16'h4456, 0, 0, 1'b1);
        one("addi", 16'h5a5f, 3, 0, 1'b0);
        one("st_wait2", 16'h7321, 1, 2, 1'b0);
        one("st", 16'h7321, 0, 0, 1'b1);
        one("jmp", 16'h90f8, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ins = {4'($urandom_range(0, 14)), 12'($urandom_range(0, 4095))};
            cf = rbit();
            one($sformatf("rnd%0d_%h", i, ins), ins,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), cf);
        end

        // Reset arrives while a load waits in MEM_RD.
        plan(16'h6120, 0, 5, 1'b0, 0);
        run("ld_abort", 1'b0, 5);
        do_reset(2);
        one("after_abort", 16'h0123, 0, 0, 1'b0);

        // HALT stays put until reset.
        plan(16'hF000, 0, 0, 1'b0, 20);
        run("halt", 1'b0, 1000);
        do_reset(2);
        one("after_halt", 16'h2123, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
